clk_edge_meas: RTL and testbench

- Receive-side companion to the on-chip clock divider.
- Takes a slow, asynchronous external clock (I2S BCLK/LRCLK, or a divided clock looped back) into the clk_in domain.
- Produces one-cycle rise/fall strobes and measures the rising-edge period in clk_in cycles.
- Declares lock when the period is stable, and flags loss when edges stop.
- Feeds the amplifier interface sequencer, which gates audio output on `locked`.

---
 rtl/clk_edge_meas_if.sv | 23 ++
 rtl/clk_edge_meas.sv | 151 +++++++++++++++
 tb/tb_clk_edge_meas.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/clk_edge_meas_if.sv
// Measurement bundle between the external-clock measurement block and its
// consumer (amplifier interface sequencer). The measurement block is the master.
interface clk_edge_meas_if #(
  parameter int CNT_W = 8
);
  logic             clk_ext;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             lost;

  modport master (
    input  clk_ext,
    output rise_pulse, fall_pulse, period, period_valid, locked, lost
  );

  modport slave (
    output clk_ext,
    input  rise_pulse, fall_pulse, period, period_valid, locked, lost
  );
endinterface

// File: rtl/clk_edge_meas.sv
// Brings a slow asynchronous external clock into the clk_in domain, emits
// rise/fall strobes, measures the rising-edge period, and tracks lock/loss.
module clk_edge_meas #(
  parameter int CNT_W  = 8,
  parameter int LOCK_N = 4,
  parameter int TOL    = 1
) (
  input  logic              clk_in,
  input  logic              resetb,
  clk_edge_meas_if.master   meas
);

  localparam int                 MATCH_W    = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [CNT_W:0]     TOL_V      = (CNT_W + 1)'(TOL);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_N - 1);
  localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(LOCK_N);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_TRACK  = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  logic               sync1, sync2, hist;
  logic               rise_i, fall_i;
  logic               rise_q, fall_q;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   period_q;
  logic [MATCH_W-1:0] match_q;
  logic [1:0]         state;
  logic               valid_q, locked_q, lost_q;
  logic [CNT_W:0]     diff;
  logic               in_tol;

  // Two-flop synchroniser plus history flop for edge detection.
  // NOTE: reset is synchronous (sampled on clk_in), so it sits inside the
  // clocked branch and not in the sensitivity list; state uses <= so every
  // flop samples pre-edge values and the shift chain cannot collapse.
  always_ff @(posedge clk_in) begin
    if (!resetb) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= meas.clk_ext;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rise_i = sync2 & ~hist;
  assign fall_i = ~sync2 & hist;

  // Registered one-cycle edge strobes.
  always_ff @(posedge clk_in) begin
    if (!resetb) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_i;
      fall_q <= fall_i;
    end
  end

  // Free-running period counter, restarted at 1 on each rise, saturating at max.
  always_ff @(posedge clk_in) begin
    if (!resetb) begin
      cnt <= '0;
    end else if (rise_i) begin
      cnt <= CNT_W'(1);
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Absolute difference between the new count and the previous period, one
  // bit wider than the counter so neither ordering can wrap.
  // NOTE: every output of this block is assigned on all paths so no latch forms.
  always_comb begin
    if (cnt >= period_q) begin
      diff = {1'b0, cnt} - {1'b0, period_q};
    end else begin
      diff = {1'b0, period_q} - {1'b0, cnt};
    end
    in_tol = (diff <= TOL_V);
  end

  // Lock state machine; all updates land on the edge that raises rise_pulse.
  always_ff @(posedge clk_in) begin
    if (!resetb) begin
      state    <= ST_IDLE;
      period_q <= '0;
      match_q  <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      lost_q <= 1'b0;
      if (state != ST_IDLE && cnt == CNT_MAX) begin
        // Timeout, or a rise whose period is out of range: drop the
        // measurement; a coincident rise becomes the new reference.
        lost_q   <= 1'b1;
        valid_q  <= 1'b0;
        locked_q <= 1'b0;
        match_q  <= '0;
        state    <= rise_i ? ST_ARMED : ST_IDLE;
      end else if (rise_i) begin
        case (state)
          ST_IDLE: begin
            state <= ST_ARMED;
          end
          ST_ARMED: begin
            state    <= ST_TRACK;
            period_q <= cnt;
            valid_q  <= 1'b1;
            match_q  <= '0;
          end
          ST_TRACK: begin
            period_q <= cnt;
            if (!in_tol) begin
              match_q <= '0;
            end else if (match_q == MATCH_LAST) begin
              match_q  <= MATCH_FULL;
              locked_q <= 1'b1;
              state    <= ST_LOCKED;
            end else begin
              match_q <= match_q + 1'b1;
            end
          end
          ST_LOCKED: begin
            period_q <= cnt;
            if (!in_tol) begin
              state    <= ST_TRACK;
              match_q  <= '0;
              locked_q <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign meas.rise_pulse   = rise_q;
  assign meas.fall_pulse   = fall_q;
  assign meas.period       = period_q;
  assign meas.period_valid = valid_q;
  assign meas.locked       = locked_q;
  assign meas.lost         = lost_q;

endmodule

// File: tb/tb_clk_edge_meas.sv
// Scoreboard bench for clk_edge_meas: the stimulus pushes the expected strobe
// (kind, cycle, period, period_valid, locked) and a monitor pops on each strobe.
module tb_clk_edge_meas;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {EV_RISE, EV_FALL, EV_LOST} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       cyc;
    int       period;
    int       pv;
    int       lk;
  } want_t;

  logic  clk_in = 1'b0;
  logic  resetb;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    last_rise_cyc = 0;
  want_t want_q[$];

  clk_edge_meas_if #(.CNT_W(CNT_W)) meas ();

  clk_edge_meas #(.CNT_W(CNT_W), .LOCK_N(4), .TOL(1)) dut (
    .clk_in (clk_in),
    .resetb (resetb),
    .meas   (meas)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push(input ev_kind_e k, input int c, input int p, input int pv, input int lk);
    want_t w;
    w.kind = k; w.cyc = c; w.period = p; w.pv = pv; w.lk = lk;
    want_q.push_back(w);
  endtask

  // Called at a negedge: a clk_ext change made now is sampled at the next
  // posedge (edge k) and its strobe is seen at the negedge three cycles on.
  task automatic ext_cycle(input int hi, input int lo, input int p, input int pv,
                           input int lk, input bit with_lost = 1'b0);
    meas.clk_ext = 1'b1;
    push(EV_RISE, cyc + 3, p, pv, lk);
    if (with_lost) push(EV_LOST, cyc + 3, p, 0, 0);
    last_rise_cyc = cyc + 3;
    repeat (hi) @(negedge clk_in);
    meas.clk_ext = 1'b0;
    push(EV_FALL, cyc + 3, 0, 0, 0);
    repeat (lo) @(negedge clk_in);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rise"},   int'(meas.rise_pulse),   0);
    check({tag, "_fall"},   int'(meas.fall_pulse),   0);
    check({tag, "_period"}, int'(meas.period),       0);
    check({tag, "_valid"},  int'(meas.period_valid), 0);
    check({tag, "_locked"}, int'(meas.locked),       0);
    check({tag, "_lost"},   int'(meas.lost),         0);
  endtask

  task automatic take(input ev_kind_e k);
    want_t w;
    if (want_q.size() == 0) begin
      check("unexpected_strobe", int'(k), -1);
      return;
    end
    w = want_q.pop_front();
    check("strobe_kind",  int'(k), int'(w.kind));
    check("strobe_cycle", cyc, w.cyc);
    if (k != EV_FALL) begin
      check("period",       int'(meas.period),       w.period);
      check("period_valid", int'(meas.period_valid), w.pv);
      check("locked",       int'(meas.locked),       w.lk);
    end
  endtask

  // Monitor: every strobe seen at a negedge must match the head of the queue.
  always @(negedge clk_in) begin
    if (meas.rise_pulse === 1'b1) take(EV_RISE);
    if (meas.fall_pulse === 1'b1) take(EV_FALL);
    if (meas.lost === 1'b1)       take(EV_LOST);
  end

  // Tolerance / re-lock sequence: own cycle length and expectation at each rise.
  int tl_lo[12] = '{32, 33, 32, 31, 32, 35, 32, 32, 32, 32, 32, 32};
  int tl_p [12] = '{64, 64, 65, 64, 63, 64, 67, 64, 64, 64, 64, 64};
  int tl_pv[12] = '{ 0,  1,  1,  1,  1,  1,  1,  1,  1,  1,  1,  1};
  int tl_lk[12] = '{ 0,  0,  0,  0,  0,  1,  0,  0,  0,  0,  0,  1};

  initial begin
    resetb       = 1'b0;
    meas.clk_ext = 1'b0;
    repeat (4) @(negedge clk_in);
    check_all_zero("reset");
    resetb = 1'b1;
    @(negedge clk_in);

    // Lock acquisition at period 64.
    ext_cycle(32, 32, 0, 0, 0);
    repeat (4) ext_cycle(32, 32, 64, 1, 0);
    ext_cycle(32, 32, 64, 1, 1);

    // Timeout: clk_ext held low after the last rise.
    push(EV_LOST, last_rise_cyc + 255, 64, 0, 0);
    repeat (230) @(negedge clk_in);
    check("timeout_locked", int'(meas.locked),       0);
    check("timeout_valid",  int'(meas.period_valid), 0);
    check("timeout_period", int'(meas.period),       64);

    // Re-arm, tolerance window, unlock on 67, re-lock.
    for (int i = 0; i < 12; i++) ext_cycle(32, tl_lo[i], tl_p[i], tl_pv[i], tl_lk[i]);

    // Duty: high 10, low 54.
    ext_cycle(10, 54, 64, 1, 1);
    ext_cycle(32, 32, 64, 1, 1);

    // Out-of-range rise at cnt == 255, then a 40-cycle period.
    ext_cycle(32, 223, 64, 1, 1);
    ext_cycle(20, 20, 64, 0, 0, 1'b1);
    ext_cycle(32, 32, 40, 1, 0);

    // Re-lock at 64 before the reset test.
    repeat (4) ext_cycle(32, 32, 64, 1, 0);
    ext_cycle(32, 32, 64, 1, 1);
    check("pre_reset_locked", int'(meas.locked), 1);

    // One-cycle reset while locked, clk_ext high across release.
    resetb       = 1'b0;
    meas.clk_ext = 1'b1;
    @(negedge clk_in);
    check_all_zero("mid_reset");
    resetb = 1'b1;
    push(EV_RISE, cyc + 3, 0, 0, 0);
    repeat (32) @(negedge clk_in);
    meas.clk_ext = 1'b0;
    push(EV_FALL, cyc + 3, 0, 0, 0);
    repeat (32) @(negedge clk_in);
    ext_cycle(32, 32, 64, 1, 0);

    for (int i = 0; i < 100 && want_q.size() != 0; i++) @(negedge clk_in);
    check("strobes_outstanding", want_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
